// File: rtl/tt_um_rr_request_arbiter.sv
// Round-robin / fixed-priority request arbiter with registered status outputs.
// Optional hold-limit timeout enabled by defining ARB_HOLD_TIMEOUT_EN.
module tt_um_rr_request_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e     state_q;
  logic [2:0] gnt_idx_q;
  logic [2:0] ptr_q;
  logic       tmo_q;

  logic       release_in;
  logic       mode_in;
  logic       timeout_hit;
  logic       grant_end;
  logic [2:0] win_idx;
  logic [2:0] cand_idx;

  assign release_in = uio_in[0];
  assign mode_in    = uio_in[1];

  // Round-robin: scan offsets high to low so the smallest offset from ptr_q wins.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    win_idx  = '0;
    cand_idx = '0;
    if (mode_in) begin
      for (int i = 0; i < 8; i++) begin
        if (ui_in[i]) win_idx = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        cand_idx = ptr_q + 3'(i);
        if (ui_in[cand_idx]) win_idx = cand_idx;
      end
    end
  end

`ifdef ARB_HOLD_TIMEOUT_EN
  logic [3:0] hold_cnt_q;
  logic [3:0] hold_lim;
  logic       unused_ok;

  assign hold_lim    = uio_in[7:4];
  // hold_cnt_q counts completed GRANT cycles, so the L-th cycle sees L-1.
  assign timeout_hit = (state_q == GRANT) && (hold_lim != 4'd0) &&
                       (hold_cnt_q == hold_lim - 4'd1);
  assign unused_ok   = &{1'b0, ena, uio_in[3:2]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_q + 4'd1;
    end
  end
`else
  logic unused_ok;

  assign timeout_hit = 1'b0;
  assign unused_ok   = &{1'b0, ena, uio_in[7:2]};
`endif

  assign grant_end = release_in | ~ui_in[gnt_idx_q] | timeout_hit;

  // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_idx_q <= '0;
      ptr_q     <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|ui_in) begin
            state_q   <= GRANT;
            gnt_idx_q <= win_idx;
          end
        end
        GRANT: begin
          if (grant_end) begin
            state_q <= IDLE;
            ptr_q   <= gnt_idx_q + 3'd1;
            tmo_q   <= timeout_hit;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign uo_out  = {tmo_q, ptr_q, (state_q == GRANT), gnt_idx_q};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_rr_request_arbiter.sv
// Scoreboard bench: stimulus pushes model-predicted uo_out, a monitor pops and compares.
module tb_tt_um_rr_request_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: holder = -1 when nobody holds the resource.
  int m_holder = -1;
  int m_idx    = 0;
  int m_ptr    = 0;
  int m_held   = 0;
  bit m_tmo    = 1'b0;

  tt_um_rr_request_arbiter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] req, input bit fixed, input int ptr);
    if (fixed) begin
      for (int i = 7; i >= 0; i--) if (req[i]) return i;
    end else begin
      for (int off = 0; off < 8; off++) if (req[(ptr + off) % 8]) return (ptr + off) % 8;
    end
    return 0;
  endfunction

  task automatic model_step(input bit rst, input logic [7:0] req, input bit rel,
                            input bit fixed, input int lim);
    bit to;
    if (!rst) begin
      m_holder = -1; m_idx = 0; m_ptr = 0; m_held = 0; m_tmo = 1'b0;
      return;
    end
    m_tmo = 1'b0;
    if (m_holder < 0) begin
      if (req != 8'h00) begin
        m_holder = pick(req, fixed, m_ptr);
        m_idx    = m_holder;
        m_held   = 1;
      end
    end else begin
`ifdef ARB_HOLD_TIMEOUT_EN
      to = (lim != 0) && (m_held == lim);
`else
      to = 1'b0;
`endif
      if (rel || !req[m_holder] || to) begin
        m_ptr    = (m_holder + 1) % 8;
        m_holder = -1;
        m_tmo    = to;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic step(input string name, input bit rst, input logic [7:0] req,
                      input bit rel, input bit fixed, input logic [3:0] lim);
    exp_t e;
    @(negedge clk);
    rst_n  = rst;
    ena    = 1'($urandom);
    ui_in  = req;
    uio_in = {lim, 2'($urandom), fixed, rel};
    model_step(rst, req, rel, fixed, int'(lim));
    e.name = name;
    e.val  = {m_tmo, 3'(m_ptr), (m_holder >= 0), 3'(m_idx)};
    exp_q.push_back(e);
  endtask

  // Monitor: compares every presented output cycle against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, uo_out, e.val);
        check("uio_out", uio_out, 8'h00);
        check("uio_oe", uio_oe, 8'h00);
      end
    end
  end

  initial begin
    logic [7:0] req;
    logic [3:0] lim;
    bit         rel;
    bit         fixed;
    bit         rst;

    rst_n = 1'b0; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;

    // Idle after reset: all-zero status.
    step("reset", 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    step("reset", 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 5; i++) step("idle_zero", 1'b1, 8'h00, 1'b0, 1'b0, 4'd0);

    // Round-robin alternation between requesters 0 and 7.
    for (int i = 0; i < 9; i++) step("rr_81", 1'b1, 8'h81, (m_holder >= 0), 1'b0, 4'd0);
    step("rr_81_drop", 1'b1, 8'h00, 1'b0, 1'b0, 4'd0);
    step("rr_81_drop", 1'b1, 8'h00, 1'b0, 1'b0, 4'd0);

    // Fixed priority: highest wins, dropping it hands over to the next one.
    step("fixed_15", 1'b1, 8'h15, 1'b0, 1'b1, 4'd0);
    step("fixed_15", 1'b1, 8'h15, 1'b0, 1'b1, 4'd0);
    step("fixed_drop4", 1'b1, 8'h05, 1'b0, 1'b1, 4'd0);
    step("fixed_next", 1'b1, 8'h05, 1'b0, 1'b1, 4'd0);
    step("fixed_next", 1'b1, 8'h05, 1'b0, 1'b1, 4'd0);
    step("release_idle", 1'b1, 8'h00, 1'b1, 1'b1, 4'd0);
    step("release_idle", 1'b1, 8'h00, 1'b1, 1'b1, 4'd0);

    // Reset during a grant of index 5, then RR from pointer 0.
    step("rst_mid", 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    step("grant5", 1'b1, 8'h20, 1'b0, 1'b0, 4'd0);
    step("grant5", 1'b1, 8'h20, 1'b0, 1'b0, 4'd0);
    step("rst_mid", 1'b0, 8'h20, 1'b0, 1'b0, 4'd0);
    step("post_rst_60", 1'b1, 8'h60, 1'b0, 1'b0, 4'd0);
    step("post_rst_60", 1'b1, 8'h60, 1'b1, 1'b0, 4'd0);
    step("post_rst_60", 1'b1, 8'h60, 1'b0, 1'b0, 4'd0);

    // Hold limit 3 with a persistent requester (timeout pulse only when enabled).
    step("limit3", 1'b1, 8'h00, 1'b0, 1'b0, 4'd3);
    for (int i = 0; i < 10; i++) step("limit3", 1'b1, 8'h02, 1'b0, 1'b0, 4'd3);
    step("limit3_rel_same", 1'b1, 8'h02, 1'b1, 1'b0, 4'd3);
    step("limit3", 1'b1, 8'h00, 1'b0, 1'b0, 4'd3);

    // Randomized traffic with mode flips, releases and rare resets.
    fixed = 1'b0;
    lim   = 4'd0;
    for (int i = 0; i < 600; i++) begin
      req = ($urandom_range(0, 4) == 0) ? 8'h00 : (8'($urandom) & 8'($urandom));
      rel = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 19) == 0) fixed = ~fixed;
      if (m_holder < 0 && $urandom_range(0, 15) == 0) lim = 4'($urandom_range(0, 5));
      if (m_holder >= 0 && $urandom_range(0, 2) != 0) req[m_holder] = 1'b1;
      step("random", rst, req, rel, fixed, lim);
    end

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
